// File: rtl/touch_pkg.sv
// ============================================================================
// touch_pkg : shared constants and bit-FSM state type for the touch TX path
// Rev 1.0
// ============================================================================
`default_nettype none

package touch_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'h55;
  localparam logic [7:0] TOUCH_ENABLE  = 8'h12;
  localparam logic [7:0] TOUCH_DISABLE = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// uart_tx_byte : 8N1 byte serialiser, LSB first, registered line output
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_byte
  import touch_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       txd_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_C = CW'(DIV - 1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          w_tick;

  assign w_tick = (cnt_q == TICK_C);
  // Ready on the last stop cycle too, so the next start bit follows with no idle gap.
  assign byte_ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && w_tick);
  assign txd_o = txd_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (byte_valid_i) begin
            state_q <= ST_START;
            shift_q <= byte_data_i;
            txd_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (w_tick) begin
            cnt_q <= '0;
            if (byte_valid_i) begin
              state_q <= ST_START;
              shift_q <= byte_data_i;
              txd_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/touch_cmd_tx.sv
// ============================================================================
// touch_cmd_tx : frames a CPU command as SYNC, length, payload onto a UART line
// Rev 1.0
// ============================================================================
`default_nettype none

module touch_cmd_tx
  import touch_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 9600,
  parameter int MAX_LEN = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_len,
  input  logic [8*MAX_LEN-1:0]   cmd_data,
  output logic                   TXD,
  output logic                   busy,
  output logic                   done,
  output logic                   len_clamped
);

  localparam int         DIV       = CLK_HZ / BAUD;
  localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

  logic                 busy_q;
  logic                 done_q;
  logic                 clamped_q;
  logic [3:0]           len_q;
  logic [4:0]           idx_q;
  logic [8*MAX_LEN-1:0] data_q;

  logic       w_accept;
  logic       w_byte_done;
  logic       w_more;
  logic       w_over;
  logic       w_byte_valid;
  logic       w_byte_ready;
  logic [7:0] w_byte_data;

  assign cmd_ready   = ~busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign len_clamped = clamped_q;

  assign w_accept    = cmd_valid && !busy_q;
  assign w_over      = (cmd_len > MAX_LEN_C);
  // While a frame is running the serialiser is only ready at the end of a stop bit.
  assign w_byte_done = busy_q && w_byte_ready;
  assign w_more      = (idx_q < ({1'b0, len_q} + 5'd1));
  assign w_byte_valid = w_accept || (w_byte_done && w_more);

  always_comb begin
    w_byte_data = data_q[7:0];
    if (w_accept) begin
      w_byte_data = SYNC_BYTE;
    end else if (idx_q == 5'd0) begin
      w_byte_data = {4'd0, len_q};
    end
  end

  // Payload is consumed from the low byte; data_q shifts down as each byte is handed over.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        busy_q <= 1'b1;
        idx_q  <= '0;
        len_q  <= w_over ? MAX_LEN_C : cmd_len;
        data_q <= cmd_data;
        if (w_over) begin
          clamped_q <= 1'b1;
        end
      end else if (w_byte_done) begin
        if (w_more) begin
          idx_q <= idx_q + 5'd1;
          if (idx_q != 5'd0) begin
            data_q <= data_q >> 8;
          end
        end else begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_uart_tx_byte (
    .clk_i        (CLOCK_50),
    .rst_i        (reset),
    .byte_valid_i (w_byte_valid),
    .byte_data_i  (w_byte_data),
    .byte_ready_o (w_byte_ready),
    .txd_o        (TXD)
  );

endmodule

`default_nettype wire

// File: tb/tb_touch_cmd_tx.sv
// ============================================================================
// tb_touch_cmd_tx : directed self-checking bench for touch_cmd_tx (DIV = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_touch_cmd_tx;

  localparam int MAX_LEN = 8;
  localparam int DIV     = 4;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_data;
  logic                 TXD;
  logic                 busy;
  logic                 done;
  logic                 len_clamped;

  int n_vec = 0;
  int n_err = 0;

  touch_cmd_tx #(
    .CLK_HZ  (40),
    .BAUD    (10),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .TXD         (TXD),
    .busy        (busy),
    .done        (done),
    .len_clamped (len_clamped)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line waveform of one 8N1 byte, one entry per clock cycle.
  function automatic logic [39:0] byte_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] w;
    bits = {1'b1, b, 1'b0};
    w = '0;
    for (int p = 0; p < 10; p++)
      for (int c = 0; c < DIV; c++)
        w[p*DIV + c] = bits[p];
    return w;
  endfunction

  // Present a command at a negedge, let it be accepted, then scramble the inputs.
  task automatic issue(input logic [3:0] len, input logic [63:0] data);
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    cmd_len   = 4'($urandom);
    cmd_data  = {$urandom, $urandom};
  endtask

  // Called just after the accepting edge; checks every line cycle and the done cycle.
  task automatic expect_frame(input logic [3:0] len, input logic [63:0] data);
    int          nb;
    int          dn_seen;
    int          rdy_seen;
    logic [7:0]  eb;
    logic [39:0] obs;
    nb       = ((len > 4'd8) ? 8 : int'(len)) + 2;
    dn_seen  = 0;
    rdy_seen = 0;
    for (int j = 0; j < nb; j++) begin
      if (j == 0)      eb = 8'h55;
      else if (j == 1) eb = 8'(nb - 2);
      else             eb = data[8*(j-2) +: 8];
      obs = '0;
      for (int c = 0; c < 10*DIV; c++) begin
        @(negedge CLOCK_50);
        obs[c] = TXD;
        if (done)      dn_seen++;
        if (cmd_ready) rdy_seen++;
      end
      chk($sformatf("byte%0d", j), 64'(obs), 64'(byte_wave(eb)));
    end
    chk("done_during_frame", 64'(dn_seen), 64'd0);
    chk("ready_during_frame", 64'(rdy_seen), 64'd0);
    @(negedge CLOCK_50);
    chk("done_pulse", 64'(done), 64'd1);
    chk("ready_at_done", 64'(cmd_ready), 64'd1);
    chk("idle_at_done", 64'(TXD), 64'd1);
  endtask

  initial begin
    int dn_cnt;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 4'd1;
    cmd_data  = 64'h12;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_txd", 64'(TXD), 64'd1);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_clamped", 64'(len_clamped), 64'd0);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    chk("post_rst_txd", 64'(TXD), 64'd1);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Single payload byte.
    issue(4'd1, 64'h12);
    expect_frame(4'd1, 64'h12);
    @(negedge CLOCK_50);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("no_clamp", 64'(len_clamped), 64'd0);

    // Zero-length frame.
    issue(4'd0, 64'hDEAD_BEEF_0000_0013);
    expect_frame(4'd0, 64'h0);

    // Over-length command clamps to MAX_LEN.
    issue(4'd12, 64'h8877_6655_4433_2211);
    expect_frame(4'd12, 64'h8877_6655_4433_2211);
    chk("clamped", 64'(len_clamped), 64'd1);

    // Back-to-back: second command held valid through frame 1.
    @(negedge CLOCK_50);
    cmd_valid = 1'b1;
    cmd_len   = 4'd2;
    cmd_data  = 64'hC3A5;
    @(posedge CLOCK_50);
    #1;
    cmd_len   = 4'd3;
    cmd_data  = 64'h3C_0F_81;
    expect_frame(4'd2, 64'hC3A5);
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    expect_frame(4'd3, 64'h3C_0F_81);
    chk("clamp_sticky", 64'(len_clamped), 64'd1);

    // Reset during payload bit 3 (line low there since byte is 0xF0).
    issue(4'd2, 64'h0FF0);
    repeat (98) @(negedge CLOCK_50);
    chk("pre_abort_bit3", 64'(TXD), 64'd0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("abort_txd", 64'(TXD), 64'd1);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_clamp_clr", 64'(len_clamped), 64'd0);
    @(negedge CLOCK_50);
    reset  = 1'b0;
    dn_cnt = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (done) dn_cnt++;
      if (!TXD) dn_cnt += 100;
    end
    chk("abort_quiet", 64'(dn_cnt), 64'd0);
    issue(4'd3, 64'h13_12_55);
    expect_frame(4'd3, 64'h13_12_55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
